// File: rtl/vga_uart_pkg.sv
// Shared definitions for the UART pattern-select front end of top_VGA.
// Contents:
//   - receiver FSM state encoding
//   - ASCII digit base and pattern-select width
//   - default bit period for a 25 MHz clock at 115200 baud
//   - helper that recognises a pattern-select command byte
package vga_uart_pkg;

  // 25 MHz / 115200 baud, rounded.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;

  localparam int unsigned PATTERN_SEL_W    = 3;
  localparam logic [7:0]  ASCII_DIGIT_BASE = 8'h30;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle    = 3'd0;
  localparam rx_state_t StStart   = 3'd1;
  localparam rx_state_t StData    = 3'd2;
  localparam rx_state_t StStop    = 3'd3;
  localparam rx_state_t StCleanup = 3'd4;
  localparam rx_state_t StBreak   = 3'd5;

  // True when b is ASCII '0' .. '0'+num_patterns-1.
  function automatic logic is_pattern_cmd(input logic [7:0] b, input int unsigned num_patterns);
    logic [7:0] offset;
    offset = b - ASCII_DIGIT_BASE;
    return (b >= ASCII_DIGIT_BASE) && (32'(offset) < num_patterns);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
// Ports:
//   CLK          system clock
//   RST          asynchronous active-high reset
//   i_RX_Serial  serial line, asynchronous to CLK, idles high
//   o_RX_DV      one-cycle pulse, o_RX_Byte holds a freshly received byte
//   o_RX_Byte    last valid received byte
//   o_Frame_Err  one-cycle pulse, stop bit was sampled low
//   o_Byte_Done  combinational: a good stop bit is being sampled this cycle
//                (o_RX_DV follows on the next cycle)
//   o_Byte_Next  combinational: the byte that o_RX_Byte loads when o_Byte_Done
module uart_rx_byte
  import vga_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Byte_Done,
  output logic [7:0] o_Byte_Next
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_s;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       byte_q, byte_d;

  logic stop_sample;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State register and datapath flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic. The counter restarts at every sample point so that
  // START waits half a bit and every later state waits a whole bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          // LSB first: shift right, new bit enters at the top.
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          state_d = rx_s ? StCleanup : StBreak;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCleanup: state_d = StIdle;
      // Wait out a held-low line so it yields only one frame error.
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    stop_sample = (state_q == StStop) && (cnt_q == CNT_BIT_END);
    dv_d        = stop_sample && rx_s;
    ferr_d      = stop_sample && !rx_s;
    byte_d      = dv_d ? shift_q : byte_q;
  end

  assign o_RX_DV     = dv_q;
  assign o_RX_Byte   = byte_q;
  assign o_Frame_Err = ferr_q;
  assign o_Byte_Done = dv_d;
  assign o_Byte_Next = shift_q;

endmodule

// File: rtl/uart_pattern_ctrl.sv
// UART command front end for the VGA pattern generator. Receives 8N1 bytes
// and turns ASCII digits into a registered pattern select.
// Ports:
//   CLK            system clock (pixel clock domain)
//   RST            asynchronous active-high reset
//   i_RX_Serial    UART RX line, idles high
//   o_RX_DV        one-cycle pulse per valid received byte
//   o_RX_Byte      last valid received byte
//   o_Frame_Err    one-cycle pulse when the stop bit is low
//   o_Pattern_Sel  current pattern select
module uart_pattern_ctrl
  import vga_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned NUM_PATTERNS = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_RX_Serial,
  output logic                     o_RX_DV,
  output logic [7:0]               o_RX_Byte,
  output logic                     o_Frame_Err,
  output logic [PATTERN_SEL_W-1:0] o_Pattern_Sel
);

  logic                     byte_done;
  logic [7:0]               byte_next;
  logic [PATTERN_SEL_W-1:0] sel_q, sel_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_DV    (o_RX_DV),
    .o_RX_Byte  (o_RX_Byte),
    .o_Frame_Err(o_Frame_Err),
    .o_Byte_Done(byte_done),
    .o_Byte_Next(byte_next)
  );

  // Decoding the pre-register byte lets the select change on the same edge
  // that raises o_RX_DV.
  always_comb begin
    sel_d = sel_q;
    if (byte_done && is_pattern_cmd(byte_next, NUM_PATTERNS)) begin
      sel_d = byte_next[PATTERN_SEL_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sel_q <= '0;
    else     sel_q <= sel_d;
  end

  assign o_Pattern_Sel = sel_q;

endmodule

// File: tb/tb_uart_pattern_ctrl.sv
module tb_uart_pattern_ctrl;
  import vga_uart_pkg::*;

  localparam int unsigned CPB = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_RX_Serial = 1'b1;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_Frame_Err;
  logic [2:0] o_Pattern_Sel;

  uart_pattern_ctrl #(
    .CLKS_PER_BIT(CPB),
    .NUM_PATTERNS(8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_RX_Serial  (i_RX_Serial),
    .o_RX_DV      (o_RX_DV),
    .o_RX_Byte    (o_RX_Byte),
    .o_Frame_Err  (o_Frame_Err),
    .o_Pattern_Sel(o_Pattern_Sel)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         dv_rises = 0, dv_high = 0, ferr_rises = 0, ferr_high = 0, both_count = 0;
  logic       dv_prev = 1'b0, ferr_prev = 1'b0;
  logic [2:0] sel_prev = 3'd0;
  int         dv_cyc[16];
  logic [2:0] sel_at_dv[16];
  logic [2:0] sel_before_dv[16];

  always @(negedge CLK) begin
    if (o_RX_DV) dv_high++;
    if (o_Frame_Err) ferr_high++;
    if (o_RX_DV && o_Frame_Err) both_count++;
    if (o_RX_DV && !dv_prev) begin
      dv_cyc[dv_rises % 16]        = cyc;
      sel_at_dv[dv_rises % 16]     = o_Pattern_Sel;
      sel_before_dv[dv_rises % 16] = sel_prev;
      dv_rises++;
    end
    if (o_Frame_Err && !ferr_prev) ferr_rises++;
    dv_prev   = o_RX_DV;
    ferr_prev = o_Frame_Err;
    sel_prev  = o_Pattern_Sel;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, ending 1 time unit after a rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int last_start;

  // Sends one 10-bit frame; caller is aligned 1 unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start  = cyc;
    i_RX_Serial = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = b[i];
      hold(CPB);
    end
    i_RX_Serial = stop_bit;
    hold(CPB);
    i_RX_Serial = 1'b1;
  endtask

  int r0, f0;

  initial begin
    // Reset state.
    hold(3);
    check_eq("rst_dv", 32'(o_RX_DV), 32'd0);
    check_eq("rst_byte", 32'(o_RX_Byte), 32'h00);
    check_eq("rst_ferr", 32'(o_Frame_Err), 32'd0);
    check_eq("rst_sel", 32'(o_Pattern_Sel), 32'd0);
    RST = 1'b0;
    hold(5);

    // '3': latency 79, single-cycle pulse, select changes on the DV edge.
    send_frame(8'h33, 1'b1);
    hold(5);
    check_eq("d3_rises", 32'(dv_rises), 32'd1);
    check_eq("d3_width", 32'(dv_high), 32'd1);
    check_eq("d3_latency", 32'(dv_cyc[0] - last_start), 32'd79);
    check_eq("d3_byte", 32'(o_RX_Byte), 32'h33);
    check_eq("d3_sel_before", 32'(sel_before_dv[0]), 32'd0);
    check_eq("d3_sel_at_dv", 32'(sel_at_dv[0]), 32'd3);
    check_eq("d3_no_ferr", 32'(ferr_high), 32'd0);

    // 'A': reported but select holds.
    send_frame(8'h41, 1'b1);
    hold(5);
    check_eq("a_rises", 32'(dv_rises), 32'd2);
    check_eq("a_byte", 32'(o_RX_Byte), 32'h41);
    check_eq("a_sel", 32'(o_Pattern_Sel), 32'd3);

    // 0x35 with a low stop bit, then line released high.
    send_frame(8'h35, 1'b0);
    hold(20);
    check_eq("fe_rises", 32'(ferr_rises), 32'd1);
    check_eq("fe_width", 32'(ferr_high), 32'd1);
    check_eq("fe_no_dv", 32'(dv_rises), 32'd2);
    check_eq("fe_byte", 32'(o_RX_Byte), 32'h41);
    check_eq("fe_sel", 32'(o_Pattern_Sel), 32'd3);
    send_frame(8'h31, 1'b1);
    hold(5);
    check_eq("d1_sel", 32'(o_Pattern_Sel), 32'd1);
    check_eq("d1_byte", 32'(o_RX_Byte), 32'h31);

    // Two-cycle glitch.
    r0 = dv_rises;
    f0 = ferr_rises;
    i_RX_Serial = 1'b0;
    hold(2);
    i_RX_Serial = 1'b1;
    hold(100);
    check_eq("gl_no_dv", 32'(dv_rises), 32'(r0));
    check_eq("gl_no_ferr", 32'(ferr_rises), 32'(f0));
    check_eq("gl_idle", 32'(dut.u_rx.state_q), 32'(StIdle));
    send_frame(8'h37, 1'b1);
    hold(5);
    check_eq("d7_sel", 32'(o_Pattern_Sel), 32'd7);

    // Back-to-back '7','2' with no idle gap.
    r0 = dv_rises;
    send_frame(8'h37, 1'b1);
    send_frame(8'h32, 1'b1);
    hold(5);
    check_eq("b2b_rises", 32'(dv_rises - r0), 32'd2);
    check_eq("b2b_spacing", 32'(dv_cyc[(r0 + 1) % 16] - dv_cyc[r0 % 16]), 32'd80);
    check_eq("b2b_sel_first", 32'(sel_at_dv[r0 % 16]), 32'd7);
    check_eq("b2b_sel_second", 32'(sel_at_dv[(r0 + 1) % 16]), 32'd2);
    check_eq("b2b_byte", 32'(o_RX_Byte), 32'h32);

    // Reset during data bit 4 of '6' (0x36), then leave the line idle.
    r0 = dv_rises;
    f0 = ferr_rises;
    i_RX_Serial = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      i_RX_Serial = 8'h36 >> i;
      hold(CPB);
    end
    i_RX_Serial = 1'b1;  // bit 4 of 0x36
    hold(4);
    RST = 1'b1;
    #1;
    check_eq("mr_dv", 32'(o_RX_DV), 32'd0);
    check_eq("mr_byte", 32'(o_RX_Byte), 32'h00);
    check_eq("mr_ferr", 32'(o_Frame_Err), 32'd0);
    check_eq("mr_sel", 32'(o_Pattern_Sel), 32'd0);
    hold(1);
    RST = 1'b0;
    hold(100);
    check_eq("mr_no_dv", 32'(dv_rises), 32'(r0));
    check_eq("mr_no_ferr", 32'(ferr_rises), 32'(f0));
    send_frame(8'h34, 1'b1);
    hold(5);
    check_eq("d4_sel", 32'(o_Pattern_Sel), 32'd4);
    check_eq("d4_byte", 32'(o_RX_Byte), 32'h34);

    check_eq("dv_ferr_exclusive", 32'(both_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
